// File: rtl/hdmi_out_pkg.sv
// Shared definitions for the HDMI output read path: FSM encodings, sizing defaults
// and the burst length helper used by the DDR read scheduler.
package hdmi_out_pkg;

  localparam int FIFO_DEPTH_DEF  = 128;
  localparam int BURST_WORDS_DEF = 64;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_VSYNC = 3'd1;
  localparam logic [2:0] ST_CHECK      = 3'd2;
  localparam logic [2:0] ST_REQ        = 3'd3;
  localparam logic [2:0] ST_XFER       = 3'd4;
  localparam logic [2:0] ST_ADVANCE    = 3'd5;

  // Words for the next command: the rest of the line, capped at one burst.
  function automatic logic [15:0] burst_len(input logic [15:0] line_words,
                                            input logic [15:0] word_off,
                                            input logic [15:0] burst_words);
    logic [15:0] rem;
    rem = line_words - word_off;
    return (rem < burst_words) ? rem : burst_words;
  endfunction

endpackage

// File: rtl/hdmi_rd_scheduler.sv
// Issues one DDR burst read at a time to keep the HDMI line FIFO topped up,
// walking a frame line by line with space accounting, line wrap and vsync resync.
module hdmi_rd_scheduler
  import hdmi_out_pkg::*;
#(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int BURST_WORDS = BURST_WORDS_DEF,
  parameter int CNT_W       = 8
) (
  input  logic              Bus2IP_Clk,
  input  logic              Bus2IP_Reset,
  input  logic              enable,
  input  logic              vsync,
  input  logic [31:0]       FRAME_BASE_ADDR,
  input  logic [31:0]       LINE_STRIDE,
  input  logic [15:0]       LINE_WORDS,
  input  logic [11:0]       NUM_LINES,
  input  logic [CNT_W-1:0]  fifo_wr_count,
  output logic              IP2Bus_MstRd_Req,
  output logic [31:0]       IP2Bus_Mst_Addr,
  output logic [11:0]       IP2Bus_Mst_Length,
  input  logic              Bus2IP_Mst_CmdAck,
  input  logic              Bus2IP_Mst_Cmplt,
  input  logic              Bus2IP_Mst_Error,
  output logic              busy,
  output logic              frame_done,
  output logic              rd_err
);

  logic [2:0]  state, state_nxt;
  logic [31:0] base_sh, stride_sh;
  logic [15:0] words_sh;
  logic [11:0] lines_sh;
  logic [31:0] line_base;
  logic [15:0] word_off;
  logic [11:0] line_cnt;
  logic        resync;

  logic [15:0] len;
  logic [16:0] space;
  logic        has_space, restart, cmplt_now, line_end, last_burst, load_frame;

  assign len   = burst_len(words_sh, word_off, 16'(BURST_WORDS));
  assign space = (17'(fifo_wr_count) > 17'(FIFO_DEPTH)) ? 17'd0
               : 17'(FIFO_DEPTH) - 17'(fifo_wr_count);
  assign has_space  = space >= {1'b0, len};
  assign restart    = resync | vsync;
  assign line_end   = (word_off + len) == words_sh;
  assign last_burst = line_end && ((line_cnt + 12'd1) == lines_sh);
  assign cmplt_now  = ((state == ST_REQ) && Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt) ||
                      ((state == ST_XFER) && Bus2IP_Mst_Cmplt);
  // A frame (re)starts on vsync while waiting, or on a pending resync at a safe point.
  assign load_frame = enable &&
                      (((state == ST_WAIT_VSYNC) && vsync) ||
                       (((state == ST_CHECK) || (state == ST_ADVANCE)) && restart));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (enable) state_nxt = ST_WAIT_VSYNC;
      ST_WAIT_VSYNC: begin
        if (!enable)    state_nxt = ST_IDLE;
        else if (vsync) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (!enable)        state_nxt = ST_IDLE;
        else if (restart)   state_nxt = ST_CHECK;
        else if (has_space) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (Bus2IP_Mst_CmdAck) state_nxt = Bus2IP_Mst_Cmplt ? ST_ADVANCE : ST_XFER;
      end
      ST_XFER:       if (Bus2IP_Mst_Cmplt) state_nxt = ST_ADVANCE;
      ST_ADVANCE: begin
        if (!enable)         state_nxt = ST_IDLE;
        else if (restart)    state_nxt = ST_CHECK;
        else if (last_burst) state_nxt = ST_WAIT_VSYNC;
        else                 state_nxt = ST_CHECK;
      end
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state             <= ST_IDLE;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      rd_err            <= 1'b0;
      resync            <= 1'b0;
      IP2Bus_MstRd_Req  <= 1'b0;
      IP2Bus_Mst_Addr   <= 32'd0;
      IP2Bus_Mst_Length <= 12'd0;
      base_sh           <= 32'd0;
      stride_sh         <= 32'd0;
      words_sh          <= 16'd0;
      lines_sh          <= 12'd0;
      line_base         <= 32'd0;
      word_off          <= 16'd0;
      line_cnt          <= 12'd0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != ST_IDLE);
      // A resync pending at completion means the frame is being abandoned.
      frame_done <= cmplt_now && last_burst && !resync;

      if (cmplt_now && Bus2IP_Mst_Error) rd_err <= 1'b1;

      if (load_frame || (state_nxt == ST_IDLE)) resync <= 1'b0;
      else if (vsync && ((state == ST_REQ) || (state == ST_XFER))) resync <= 1'b1;

      if (load_frame) begin
        base_sh   <= FRAME_BASE_ADDR;
        stride_sh <= LINE_STRIDE;
        words_sh  <= LINE_WORDS;
        lines_sh  <= NUM_LINES;
        line_base <= FRAME_BASE_ADDR;
        word_off  <= 16'd0;
        line_cnt  <= 12'd0;
      end else if (state == ST_ADVANCE) begin
        if (line_end) begin
          word_off  <= 16'd0;
          line_base <= line_base + stride_sh;
          line_cnt  <= line_cnt + 12'd1;
        end else begin
          word_off  <= word_off + len;
        end
      end

      // Command fields are captured once and held until the master accepts them.
      if ((state == ST_CHECK) && (state_nxt == ST_REQ)) begin
        IP2Bus_MstRd_Req  <= 1'b1;
        IP2Bus_Mst_Addr   <= line_base + {14'd0, word_off, 2'b00};
        IP2Bus_Mst_Length <= {len[9:0], 2'b00};
      end else if ((state == ST_REQ) && Bus2IP_Mst_CmdAck) begin
        IP2Bus_MstRd_Req  <= 1'b0;
      end
    end
  end

  // base_sh is kept for readback symmetry with the other shadowed fields.
  logic unused_base;
  assign unused_base = ^base_sh;

endmodule
